// File: rtl/cpu_mem_pkg.sv
// Shared constants and helpers for the CPU-side memory blocks.
package cpu_mem_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Address width needed to index n entries (at least 1 bit).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_mem_valid_ctr.sv
// Per-word valid bits with a registered occupancy count and full flag.
module cpu_mem_valid_ctr
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_set,
  input  logic [AW-1:0]    i_set_idx,
  output logic [DEPTH-1:0] o_valid,
  output logic [AW:0]      o_count,
  output logic             o_full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             w_new;
  logic [AW:0]      w_count_nxt;

  // Only a first write to a word changes occupancy, so count saturates at DEPTH.
  always_comb begin
    w_new       = i_set && !r_valid[i_set_idx];
    w_count_nxt = r_count + {{AW{1'b0}}, w_new};
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (w_new) begin
      r_valid[i_set_idx] <= 1'b1;
      r_count            <= w_count_nxt;
      r_full             <= (w_count_nxt == DEPTH_C);
    end
  end

  assign o_valid = r_valid;
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

// File: rtl/cpu_mem_bank.sv
// DEPTH x WIDTH word store: strobed writes (addressed or pointer-sequential),
// enable-gated registered read with hold, valid tracking and range errors.
module cpu_mem_bank
  import cpu_mem_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BYPASS = 1,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             seq,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  input  logic [AW-1:0]    addr_r,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_hit,
  output logic             addr_err,
  output logic [AW:0]      count,
  output logic             full,
  output logic [AW-1:0]    wptr
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_q_hit;
  logic             r_addr_err;
  logic [AW-1:0]    r_wptr;

  logic [AW-1:0]    w_waddr;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_wr;
  logic             w_bypass;
  logic [DEPTH-1:0] w_valid;

  always_comb begin
    w_waddr       = seq ? r_wptr : addr_w;
    w_wr_in_range = ({1'b0, w_waddr} < DEPTH_C);
    w_rd_in_range = ({1'b0, addr_r} < DEPTH_C);
    w_wr          = s && !clr && w_wr_in_range;
    w_bypass      = (BYPASS != 0) && w_wr && (w_waddr == addr_r);
  end

  cpu_mem_valid_ctr #(.DEPTH(DEPTH)) u_valid (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (clr),
    .i_set     (w_wr),
    .i_set_idx (w_waddr),
    .o_valid   (w_valid),
    .o_count   (count),
    .o_full    (full)
  );

  // Storage stage: contents survive rst/clr; the valid bits mask stale words.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_waddr] <= d;
  end

  // Read/pointer stage: read sees pre-write, pre-clear state unless bypassing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_q_hit    <= 1'b0;
      r_addr_err <= 1'b0;
      r_wptr     <= '0;
    end else begin
      r_q_valid  <= e;
      r_addr_err <= (s && !clr && !w_wr_in_range) || (e && !w_rd_in_range);
      if (clr) begin
        r_wptr <= '0;
      end else if (s && seq) begin
        r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + 1'b1;
      end
      if (e) begin
        if (!w_rd_in_range) begin
          r_q     <= '0;
          r_q_hit <= 1'b0;
        end else if (w_bypass) begin
          r_q     <= d;
          r_q_hit <= 1'b1;
        end else if (w_valid[addr_r]) begin
          r_q     <= r_mem[addr_r];
          r_q_hit <= 1'b1;
        end else begin
          r_q     <= '0;
          r_q_hit <= 1'b0;
        end
      end
    end
  end

  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign q_hit    = r_q_hit;
  assign addr_err = r_addr_err;
  assign wptr     = r_wptr;

endmodule

// File: tb/tb_cpu_mem_bank.sv
// Bench for cpu_mem_bank: three configurations share one stimulus stream and
// are checked every cycle against a word-level reference model.
module tb_cpu_mem_bank;

  logic       clk = 1'b0;
  logic       rst, s, seq, e, clr;
  logic [3:0] addr_w, addr_r;
  logic [7:0] d;

  // Instance 0: DEPTH 16 bypass, 1: DEPTH 16 no bypass, 2: DEPTH 10 bypass.
  logic [7:0] q_o   [3];
  logic       qv_o  [3];
  logic       hit_o [3];
  logic       err_o [3];
  logic [4:0] cnt_o [3];
  logic       full_o[3];
  logic [3:0] wp_o  [3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_bank #(.WIDTH(8), .DEPTH(16), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .s(s), .seq(seq), .addr_w(addr_w), .d(d), .e(e),
    .addr_r(addr_r), .clr(clr), .q(q_o[0]), .q_valid(qv_o[0]), .q_hit(hit_o[0]),
    .addr_err(err_o[0]), .count(cnt_o[0]), .full(full_o[0]), .wptr(wp_o[0]));

  cpu_mem_bank #(.WIDTH(8), .DEPTH(16), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .s(s), .seq(seq), .addr_w(addr_w), .d(d), .e(e),
    .addr_r(addr_r), .clr(clr), .q(q_o[1]), .q_valid(qv_o[1]), .q_hit(hit_o[1]),
    .addr_err(err_o[1]), .count(cnt_o[1]), .full(full_o[1]), .wptr(wp_o[1]));

  cpu_mem_bank #(.WIDTH(8), .DEPTH(10), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .s(s), .seq(seq), .addr_w(addr_w), .d(d), .e(e),
    .addr_r(addr_r), .clr(clr), .q(q_o[2]), .q_valid(qv_o[2]), .q_hit(hit_o[2]),
    .addr_err(err_o[2]), .count(cnt_o[2]), .full(full_o[2]), .wptr(wp_o[2]));

  // Reference model: plain arrays of words and valid flags per instance.
  int dep[3] = '{16, 16, 10};
  bit byp[3] = '{1'b1, 1'b0, 1'b1};
  int m_mem[3][16];
  bit m_val[3][16];
  int m_q[3], m_wptr[3];
  bit m_qv[3], m_hit[3], m_err[3];

  function automatic int n_valid(input int k);
    int c = 0;
    for (int i = 0; i < 16; i++) c += m_val[k][i];
    return c;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int wa, ra, dd;
      bit wr;
      dd = dep[k];
      wa = seq ? m_wptr[k] : int'(addr_w);
      ra = int'(addr_r);
      wr = s && !clr && (wa < dd);
      if (rst) begin
        m_q[k] = 0; m_qv[k] = 0; m_hit[k] = 0; m_err[k] = 0; m_wptr[k] = 0;
        for (int i = 0; i < 16; i++) m_val[k][i] = 0;
      end else begin
        m_qv[k]  = e;
        m_err[k] = (s && !clr && wa >= dd) || (e && ra >= dd);
        if (e) begin
          if (ra >= dd) begin m_q[k] = 0; m_hit[k] = 0; end
          else if (byp[k] && wr && wa == ra) begin m_q[k] = int'(d); m_hit[k] = 1; end
          else if (m_val[k][ra]) begin m_q[k] = m_mem[k][ra]; m_hit[k] = 1; end
          else begin m_q[k] = 0; m_hit[k] = 0; end
        end
        if (clr) begin
          m_wptr[k] = 0;
          for (int i = 0; i < 16; i++) m_val[k][i] = 0;
        end else if (s) begin
          if (wa < dd) begin m_mem[k][wa] = int'(d); m_val[k][wa] = 1; end
          if (seq) m_wptr[k] = (m_wptr[k] + 1) % dd;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = n_valid(k);
        check($sformatf("inst%0d q", k),        32'(q_o[k]),    32'(m_q[k]));
        check($sformatf("inst%0d q_valid", k),  32'(qv_o[k]),   32'(m_qv[k]));
        check($sformatf("inst%0d q_hit", k),    32'(hit_o[k]),  32'(m_hit[k]));
        check($sformatf("inst%0d addr_err", k), 32'(err_o[k]),  32'(m_err[k]));
        check($sformatf("inst%0d count", k),    32'(cnt_o[k]),  32'(c));
        check($sformatf("inst%0d full", k),     32'(full_o[k]), 32'(c == dep[k]));
        check($sformatf("inst%0d wptr", k),     32'(wp_o[k]),   32'(m_wptr[k]));
      end
    end
  end

  task automatic idle();
    rst = 0; s = 0; seq = 0; e = 0; clr = 0; addr_w = 0; addr_r = 0; d = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk_en = 1'b1;
    idle();

    // Read of an unwritten word after reset
    e = 1; addr_r = 4'd3;
    tick();
    check("t1 q", 32'(q_o[0]), 32'h0);
    check("t1 q_hit", 32'(hit_o[0]), 32'h0);
    check("t1 q_valid", 32'(qv_o[0]), 32'h1);
    check("t1 count", 32'(cnt_o[0]), 32'h0);

    // Addressed write then read, then hold with e=0
    idle(); s = 1; addr_w = 4'd3; d = 8'hA5;
    tick();
    idle(); e = 1; addr_r = 4'd3;
    tick();
    check("t2 q", 32'(q_o[0]), 32'hA5);
    check("t2 q_hit", 32'(hit_o[0]), 32'h1);
    check("t2 count", 32'(cnt_o[0]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle(); d = 8'(i * 16 + 7); addr_r = 4'(i);
      tick();
      check("t2 hold q", 32'(q_o[0]), 32'hA5);
      check("t2 hold q_valid", 32'(qv_o[0]), 32'h0);
    end

    // Sequential load of 18 words wraps the pointer
    for (int i = 0; i < 18; i++) begin
      idle(); s = 1; seq = 1; d = 8'(i);
      tick();
    end
    check("t3 count", 32'(cnt_o[0]), 32'd16);
    check("t3 full", 32'(full_o[0]), 32'h1);
    check("t3 wptr", 32'(wp_o[0]), 32'd2);
    check("t3 wptr d10", 32'(wp_o[2]), 32'd8);
    check("t3 full d10", 32'(full_o[2]), 32'h1);
    idle(); e = 1; addr_r = 4'd0;
    tick();
    check("t3 mem0", 32'(q_o[0]), 32'd16);
    idle(); e = 1; addr_r = 4'd1;
    tick();
    check("t3 mem1", 32'(q_o[0]), 32'd17);

    // Same-cycle write/read of an unwritten word, with and without bypass
    idle(); rst = 1;
    tick();
    idle(); s = 1; e = 1; addr_w = 4'd5; addr_r = 4'd5; d = 8'h3C;
    tick();
    check("t4 byp q", 32'(q_o[0]), 32'h3C);
    check("t4 byp hit", 32'(hit_o[0]), 32'h1);
    check("t4 nobyp q", 32'(q_o[1]), 32'h0);
    check("t4 nobyp hit", 32'(hit_o[1]), 32'h0);

    // clr beats a write; a read in the clr cycle sees pre-clear contents
    idle(); s = 1; seq = 1; d = 8'h01;
    tick();
    idle(); clr = 1; s = 1; addr_w = 4'd7; d = 8'h77; e = 1; addr_r = 4'd5;
    tick();
    check("t5 count", 32'(cnt_o[0]), 32'h0);
    check("t5 wptr", 32'(wp_o[0]), 32'h0);
    check("t5 preclr q", 32'(q_o[0]), 32'h3C);
    idle(); e = 1; addr_r = 4'd7;
    tick();
    check("t5 hit7", 32'(hit_o[0]), 32'h0);

    // Rewriting a valid word while reading it: old data without bypass
    idle(); s = 1; addr_w = 4'd2; d = 8'h11;
    tick();
    idle(); s = 1; addr_w = 4'd2; d = 8'h22; e = 1; addr_r = 4'd2;
    tick();
    check("t5b nobyp old", 32'(q_o[1]), 32'h11);
    check("t5b byp new", 32'(q_o[0]), 32'h22);
    check("t5b count", 32'(cnt_o[1]), 32'h1);

    // Out-of-range accesses on the 10-deep instance
    idle(); s = 1; addr_w = 4'd12; d = 8'h5A; e = 1; addr_r = 4'd11;
    tick();
    check("t6 err", 32'(err_o[2]), 32'h1);
    check("t6 count", 32'(cnt_o[2]), 32'h1);
    check("t6 q", 32'(q_o[2]), 32'h0);
    check("t6 q_valid", 32'(qv_o[2]), 32'h1);
    idle();
    tick();
    check("t6 err pulse", 32'(err_o[2]), 32'h0);

    // Reset during a sequential load
    for (int i = 0; i < 3; i++) begin
      idle(); s = 1; seq = 1; d = 8'(8'hC0 + i); e = 1; addr_r = 4'd0;
      tick();
    end
    rst = 1;
    tick();
    check("t7 q", 32'(q_o[0]), 32'h0);
    check("t7 q_valid", 32'(qv_o[0]), 32'h0);
    check("t7 q_hit", 32'(hit_o[0]), 32'h0);
    check("t7 count", 32'(cnt_o[2]), 32'h0);
    check("t7 wptr", 32'(wp_o[2]), 32'h0);
    check("t7 full", 32'(full_o[0]), 32'h0);
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
